// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the 10-bit processor serial
//                link (transmitter and receiver sides).
//                  tx_state_t          - transmitter frame state
//                  DATA_W_DEF          - default data bits per frame
//                  BAUD_DIV_DEF        - default clock cycles per serial bit
//                  IDLE_LVL/START_LVL  - line levels for idle/stop and start
//                  cnt_width()         - counter width, never below 1 bit
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_W_DEF   = 10;
    localparam int BAUD_DIV_DEF = 16;

    // Line levels, shared with the receiver so both ends agree on polarity.
    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

    // Width of a counter that must hold 0..n-1; a single-value counter still
    // needs one bit so the register exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_10_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_10_if
//  Description : Load handshake and serial line bundle of the transmitter.
//                  DIN  - word to transmit           (master -> slave)
//                  LD   - load request / valid       (master -> slave)
//                  RDY  - ready, load accepted on LD && RDY (slave -> master)
//                  TXD  - serial line, idles high    (slave -> master)
//                  BUSY - frame in progress          (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_10_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] DIN;
    logic              LD;
    logic              RDY;
    logic              TXD;
    logic              BUSY;

    modport master (
        output DIN,
        output LD,
        input  RDY,
        input  TXD,
        input  BUSY
    );

    modport slave (
        input  DIN,
        input  LD,
        output RDY,
        output TXD,
        output BUSY
    );

endinterface
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Bit-period timer. Pulses TICK for one cycle on the last
//                cycle of every BAUD_DIV-cycle bit period.
//                  CLK  - clock, rising edge
//                  RST  - synchronous active-high reset
//                  CLR  - restart the bit period (asserted on frame load)
//                  TICK - last cycle of the current bit period
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import serial_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic CLR,
    output logic      TICK
);

    localparam int            CW     = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    // With BAUD_DIV=1 the counter sits at 0 and every cycle is a tick.
    assign TICK = (r_cnt == C_LAST);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_cnt <= '0;
        end else if (TICK) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_tx_10.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_10
//  Description : Parallel-to-serial transmitter. Accepts one DATA_W-bit word
//                on LD && RDY and sends start bit (0), data LSB first, stop
//                bit (1), each bit lasting BAUD_DIV clocks.
//                  CLK  - clock, rising edge
//                  RST  - synchronous active-high reset
//                  bus  - serial_tx_10_if.slave (DIN, LD, RDY, TXD, BUSY)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx_10
    import serial_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    serial_tx_10_if.slave bus
);

    localparam int            BW         = cnt_width(DATA_W);
    localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_shreg;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_txd;
    logic              r_rdy;

    logic              w_load;
    logic              w_tick;
    logic [DATA_W-1:0] w_shreg_next;

    assign w_load       = bus.LD && r_rdy;
    assign w_shreg_next = r_shreg >> 1;

    // Restarting the timer on load aligns the first bit period with the
    // cycle the start bit appears on the line.
    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (w_load),
        .TICK (w_tick)
    );

    // TXD and RDY are loaded with the value belonging to the next state, so
    // the line changes on the same edge as the state transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= IDLE_LVL;
            r_rdy     <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.LD) begin
                        r_shreg <= bus.DIN;
                        r_state <= START;
                        r_txd   <= START_LVL;
                        r_rdy   <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                        r_txd     <= r_shreg[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shreg <= w_shreg_next;
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_state   <= STOP;
                            r_bit_cnt <= '0;
                            r_txd     <= IDLE_LVL;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                            r_txd     <= w_shreg_next[0];
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= IDLE_LVL;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.TXD  = r_txd;
    assign bus.RDY  = r_rdy;
    assign bus.BUSY = ~r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_10.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx_10
//  Description : Self-checking bench for serial_tx_10. Two instances:
//                index 0 with BAUD_DIV=4, index 1 with BAUD_DIV=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx_10;
    import serial_pkg::*;

    localparam int DW = 10;
    localparam int DIV [2] = '{4, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    serial_tx_10_if #(.DATA_W(DW)) bus_a ();
    serial_tx_10_if #(.DATA_W(DW)) bus_b ();

    serial_tx_10 #(.DATA_W(DW), .BAUD_DIV(4)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (bus_a.slave)
    );

    serial_tx_10 #(.DATA_W(DW), .BAUD_DIV(1)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (bus_b.slave)
    );

    logic          s_rst  [2];
    logic          s_ld   [2];
    logic [DW-1:0] s_din  [2];
    logic          s_txd  [2];
    logic          s_rdy  [2];
    logic          s_busy [2];

    assign s_rst[0]  = rst_a;
    assign s_rst[1]  = rst_b;
    assign s_ld[0]   = bus_a.LD;
    assign s_ld[1]   = bus_b.LD;
    assign s_din[0]  = bus_a.DIN;
    assign s_din[1]  = bus_b.DIN;
    assign s_txd[0]  = bus_a.TXD;
    assign s_txd[1]  = bus_b.TXD;
    assign s_rdy[0]  = bus_a.RDY;
    assign s_rdy[1]  = bus_b.RDY;
    assign s_busy[0] = bus_a.BUSY;
    assign s_busy[1] = bus_b.BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame model: a frame is a position counter over (DW+2)*DIV cycles;
    // the line level is read from bit index pos/DIV of {stop, word, start}.
    // ------------------------------------------------------------------
    logic          m_valid  [2] = '{1'b0, 1'b0};
    logic          m_active [2] = '{1'b0, 1'b0};
    int            m_pos    [2] = '{0, 0};
    logic [DW-1:0] m_word   [2];

    function automatic logic exp_txd(input int i);
        int b;
        if (!m_active[i]) return 1'b1;
        b = m_pos[i] / DIV[i];
        if (b == 0) return 1'b0;
        if (b <= DW) return m_word[i][b-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_rst[i] === 1'b1) begin
                m_valid[i]  = 1'b1;
                m_active[i] = 1'b0;
            end else if (!m_active[i]) begin
                if (s_ld[i] === 1'b1) begin
                    m_active[i] = 1'b1;
                    m_pos[i]    = 0;
                    m_word[i]   = s_din[i];
                end
            end else if (m_pos[i] == (DW + 2) * DIV[i] - 1) begin
                m_active[i] = 1'b0;
            end else begin
                m_pos[i]++;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
                chk($sformatf("txd[%0d]", i),  s_txd[i],  exp_txd(i));
                chk($sformatf("rdy[%0d]", i),  s_rdy[i],  !m_active[i]);
                chk($sformatf("busy[%0d]", i), s_busy[i], m_active[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    logic q_txd  [$];
    logic q_busy [$];

    // Collect TXD while BUSY after an accept on instance a; LD pulses with
    // 3FF after 10 busy cycles to confirm it is ignored.
    task automatic capture_a(input logic poke);
        q_txd.delete();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!bus_a.BUSY) break;
            q_txd.push_back(bus_a.TXD);
            if (poke && q_txd.size() == 10) begin
                bus_a.LD  = 1'b1;
                bus_a.DIN = 10'h3FF;
            end else begin
                bus_a.LD  = 1'b0;
            end
        end
    endtask

    task automatic check_bits_a(input string name, input logic [11:0] lit, input int base);
        logic [11:0] bits;
        bits = lit;
        for (int k = 0; k < 12; k++) begin
            if (base + k * 4 + 2 < q_txd.size())
                chk($sformatf("%s bit%0d", name, k), q_txd[base + k * 4 + 2], bits[k]);
            else
                chk($sformatf("%s bit%0d missing", name, k), 1'bx, bits[k]);
        end
    endtask

    initial begin
        logic [11:0] pat;
        int          runs [3];
        int          r;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.LD = 1'b0; bus_a.DIN = '0;
        bus_b.LD = 1'b0; bus_b.DIN = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state, then 100 idle cycles
        @(negedge clk);
        chk("reset txd", bus_a.TXD, 1'b1);
        chk("reset rdy", bus_a.RDY, 1'b1);
        chk("reset busy", bus_a.BUSY, 1'b0);
        repeat (100) @(negedge clk);
        chk("idle txd", bus_a.TXD, 1'b1);
        chk("idle busy b", bus_b.BUSY, 1'b0);

        // Single frame 2A5 with an ignored load mid-frame
        bus_a.DIN = 10'h2A5; bus_a.LD = 1'b1;
        capture_a(1'b1);
        chk_int("single busy len", q_txd.size(), 48);
        check_bits_a("single", 12'hD4A, 0);
        chk("single rdy after", bus_a.RDY, 1'b1);
        repeat (20) @(negedge clk);
        chk("no second frame", bus_a.BUSY, 1'b0);

        // Back-to-back 001 then 200 with LD held high
        bus_a.DIN = 10'h001; bus_a.LD = 1'b1;
        @(posedge clk); #1;
        bus_a.DIN = 10'h200;
        q_txd.delete(); q_busy.delete();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            q_txd.push_back(bus_a.TXD);
            q_busy.push_back(bus_a.BUSY);
            if (c > 0 && bus_a.BUSY && !q_busy[c-1]) bus_a.LD = 1'b0;
        end
        bus_a.LD = 1'b0;
        runs = '{0, 0, 0};
        r = 0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0 && q_busy[c] != q_busy[c-1]) r++;
            if (r < 3) runs[r]++;
        end
        chk_int("b2b frame1 len", runs[0], 48);
        chk_int("b2b idle gap", runs[1], 1);
        chk_int("b2b frame2 len", runs[2], 48);
        check_bits_a("b2b f1", 12'h802, 0);
        check_bits_a("b2b f2", 12'hC00, 49);
        repeat (10) @(negedge clk);

        // Reset 20 cycles into a frame, then a clean 155 frame
        bus_a.DIN = 10'h3C3; bus_a.LD = 1'b1;
        @(posedge clk); #1;
        bus_a.LD = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre-reset busy", bus_a.BUSY, 1'b1);
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("midreset txd", bus_a.TXD, 1'b1);
        chk("midreset rdy", bus_a.RDY, 1'b1);
        chk("midreset busy", bus_a.BUSY, 1'b0);
        bus_a.DIN = 10'h155; bus_a.LD = 1'b1;
        capture_a(1'b0);
        chk_int("post-reset len", q_txd.size(), 48);
        check_bits_a("post-reset", 12'hAAA, 0);

        // BAUD_DIV=1 frame
        bus_b.DIN = 10'h155; bus_b.LD = 1'b1;
        @(posedge clk); #1;
        bus_b.LD = 1'b0;
        q_txd.delete();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!bus_b.BUSY) break;
            q_txd.push_back(bus_b.TXD);
        end
        chk_int("div1 len", q_txd.size(), 12);
        pat = 12'hAAA;
        for (int k = 0; k < 12; k++) begin
            if (k < q_txd.size())
                chk($sformatf("div1 bit%0d", k), q_txd[k], pat[k]);
            else
                chk($sformatf("div1 bit%0d missing", k), 1'bx, pat[k]);
        end
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_tx_10.md
Name: serial_tx_10

Overview:
- Parallel-to-serial transmitter for the 10-bit processor's output path.
- Accepts one 10-bit word through a valid/ready handshake and shifts it out on a single line as a frame: start bit (0), DATA_W data bits LSB first, stop bit (1).
- It is the transmit end of the processor's serial link, and pairs with the serial receiver on the far side.
- All state is stored in flops on a single clock edge; the line idles high.

Parameters:
- DATA_W, 10, data bits per frame (>=1).
- BAUD_DIV, 16, clock cycles per serial bit (>=1; BAUD_DIV=1 is legal).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- DIN  input  DATA_W  word to transmit; sampled only on an accepted load.
- LD  input  1  load request (valid).
- RDY  output  1  ready; a load is accepted when LD && RDY at a clock edge.
- TXD  output  1  serial line, registered; idle = 1.
- BUSY  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset, synchronous and active-high: on any edge with RST=1 the next state is state=IDLE, TXD=1, RDY=1, BUSY=0, and the shift register, baud counter and bit counter are 0. RST has priority over LD and overrides any frame in progress; the partial frame is abandoned and the line returns high on the next cycle.
- States: IDLE, START, DATA, STOP.
- IDLE: TXD=1, RDY=1. On LD=1, capture DIN into the shift register and go to START with baud_cnt=0. No word is captured while RDY=0; LD there is ignored (no queueing, no error flag).
- START: TXD=0 for exactly BAUD_DIV cycles. When baud_cnt==BAUD_DIV-1, go to DATA with bit_cnt=0 and baud_cnt=0.
- DATA: TXD = shreg[0]. At the end of each bit period (baud_cnt==BAUD_DIV-1), shift right and increment bit_cnt. When bit_cnt==DATA_W-1 at the end of the period, go to STOP.
- STOP: TXD=1 for BAUD_DIV cycles, then go to IDLE.
- Outputs: RDY=1 only in IDLE; BUSY = !RDY.
- Latency: TXD falls on the first edge after the accepting edge, because TXD is registered from the next-state value. The frame length is exactly (DATA_W+2)*BAUD_DIV cycles of BUSY=1.
- Back-to-back: RDY rises on the first cycle after the STOP period. An LD held high is then accepted immediately, so the gap between frames is 0 extra idle bit periods (STOP to START is directly adjacent, with one IDLE cycle).
- Counter widths: baud_cnt is $clog2(BAUD_DIV) bits, minimum 1 bit. bit_cnt is $clog2(DATA_W) bits, minimum 1 bit. Neither counter ever exceeds its terminal value; wrap-around is explicit reset to 0.
- DIN changes after acceptance have no effect on the frame in progress.
- No X on any output after the first reset edge.

Decomposition:
- Package serial_pkg:
  - typedef enum logic [1:0] tx_state_t {IDLE, START, DATA, STOP}
  - localparams DATA_W_DEF=10 and BAUD_DIV_DEF=16
  - constants IDLE_LVL=1'b1 and START_LVL=1'b0, shared with the receiver.
- One sub-module, baud_tick_gen (parameter BAUD_DIV; ports CLK, RST, CLR, TICK). It produces a one-cycle TICK at the end of each bit period and restarts on CLR, which is asserted on load.
- The FSM and shift register stay in serial_tx_10.

Test Plan:
- Reset: RST=1 for 2 cycles, then release -> TXD=1, RDY=1, BUSY=0. With LD=0 these values stay stable for 100 cycles.
- Single frame, BAUD_DIV=4: DIN=10'h2A5 with LD for 1 cycle.
  - TXD sequence, 4 cycles per bit: 0 | 1,0,1,0,0,1,0,1,0,1 | 1.
  - BUSY is high for exactly 48 cycles, then RDY=1.
- Ignored load: during that frame, drive LD=1 with DIN=10'h3FF at cycle 10 -> frame bits unchanged; no second frame follows unless LD is asserted after RDY rises.
- Back-to-back, BAUD_DIV=4: hold LD=1 with DIN=10'h001 then 10'h200 -> two complete 48-cycle frames separated by exactly 1 IDLE cycle. The first frame's data bits are 1 followed by nine 0s; the second's are nine 0s followed by 1.
- Reset mid-frame: assert RST at cycle 20 of a frame -> next cycle TXD=1, RDY=1, BUSY=0. A new LD with 10'h155 then produces a clean full frame.
- BAUD_DIV=1, DIN=10'h155 -> 12-cycle frame: TXD = 0,1,0,1,0,1,0,1,0,1,0,1.
